// File: rtl/up_counter_mod_if.sv
// Control and status bundle for the wrapping up-counter: the controller drives
// the strobes and limits, and the counter returns count, terminal and wrap flags.
interface up_counter_mod_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] max_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             co;
  logic             ovf;

  modport master (
    output en, clr, load, load_val, max_val,
    input  q, tc, co, ovf
  );

  modport slave (
    input  en, clr, load, load_val, max_val,
    output q, tc, co, ovf
  );
endinterface

// File: rtl/up_counter_mod.sv
// Modulo (max_val+1) up-counter with sync clear/load, one-cycle carry pulse,
// sticky wrap flag and a combinational terminal-count output.
module up_counter_mod #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  up_counter_mod_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;
  logic             co_r;
  logic             co_nxt;
  logic             ovf_r;
  logic             ovf_nxt;
  logic             at_max;

  // ">=" so a loaded value above max_val, or a lowered max_val, wraps next time.
  assign at_max = (q_r >= bus.max_val);

  always_comb begin
    q_nxt   = q_r;
    co_nxt  = 1'b0;
    ovf_nxt = ovf_r;
    if (bus.clr) begin
      q_nxt   = '0;
      ovf_nxt = 1'b0;
    end else if (bus.load) begin
      q_nxt = bus.load_val;
    end else if (bus.en) begin
      if (at_max) begin
        q_nxt   = '0;
        co_nxt  = 1'b1;
        ovf_nxt = 1'b1;
      end else begin
        q_nxt = q_r + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r   <= '0;
      co_r  <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      q_r   <= q_nxt;
      co_r  <= co_nxt;
      ovf_r <= ovf_nxt;
    end
  end

  assign bus.q   = q_r;
  assign bus.tc  = at_max;
  assign bus.co  = co_r;
  assign bus.ovf = ovf_r;

endmodule

// File: tb/tb_up_counter_mod.sv
// Directed bench for up_counter_mod (WIDTH=4): reset, full and decade
// sequences, control priority, over-max load, async reset, enable gaps.
module tb_up_counter_mod;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  up_counter_mod_if #(.WIDTH(4)) bus ();

  up_counter_mod #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.en = 1'b1;
    bus.max_val = 4'd15;
    #1;
    checks++;
    if (bus.q !== 4'd0 || bus.co !== 1'b0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state q=%0d co=%0b ovf=%0b required q=0 co=0 ovf=0", bus.q, bus.co, bus.ovf);
    end
    tick();
    tick();
    checks++;
    if (bus.q !== 4'd0 || bus.tc !== 1'b0) begin
      errors++;
      $display("FAIL reset_holds q=%0d tc=%0b required q=0 tc=0", bus.q, bus.tc);
    end
    bus.en = 1'b0;
  endtask

  task automatic test_count_full();
    logic [3:0] eq;
    bus.max_val = 4'd15;
    rst = 1'b1;
    bus.en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      eq = 4'(i % 16);
      checks++;
      if (bus.q !== eq || bus.co !== (i == 16) || bus.ovf !== (i >= 16) || bus.tc !== (eq == 4'd15)) begin
        errors++;
        $display("FAIL full_count edge=%0d q=%0d co=%0b ovf=%0b tc=%0b required q=%0d co=%0b ovf=%0b tc=%0b",
                 i, bus.q, bus.co, bus.ovf, bus.tc, eq, (i == 16), (i >= 16), (eq == 4'd15));
      end
    end
    bus.en = 1'b0;
  endtask

  task automatic test_decade();
    logic [3:0] eq;
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    checks++;
    if (bus.q !== 4'd0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL clr q=%0d ovf=%0b required q=0 ovf=0", bus.q, bus.ovf);
    end
    bus.max_val = 4'd9;
    bus.en = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      tick();
      eq = 4'(i % 10);
      checks++;
      if (bus.q !== eq || bus.co !== (eq == 4'd0) || bus.tc !== (eq == 4'd9)) begin
        errors++;
        $display("FAIL decade edge=%0d q=%0d co=%0b tc=%0b required q=%0d co=%0b tc=%0b",
                 i, bus.q, bus.co, bus.tc, eq, (eq == 4'd0), (eq == 4'd9));
      end
    end
    bus.en = 1'b0;
  endtask

  task automatic test_clr_priority();
    bus.max_val = 4'd15;
    bus.load_val = 4'd5;
    bus.load = 1'b1;
    tick();
    checks++;
    if (bus.q !== 4'd5) begin
      errors++;
      $display("FAIL load5 q=%0d required 5", bus.q);
    end
    bus.clr = 1'b1;
    bus.load_val = 4'd12;
    bus.en = 1'b1;
    tick();
    checks++;
    if (bus.q !== 4'd0 || bus.ovf !== 1'b0 || bus.co !== 1'b0) begin
      errors++;
      $display("FAIL clr_priority q=%0d ovf=%0b co=%0b required q=0 ovf=0 co=0", bus.q, bus.ovf, bus.co);
    end
    bus.clr = 1'b0;
    bus.en = 1'b0;
    tick();
    checks++;
    if (bus.q !== 4'd12) begin
      errors++;
      $display("FAIL load_after_clr q=%0d required 12", bus.q);
    end
    bus.load = 1'b0;
  endtask

  task automatic test_load_over_max();
    bus.max_val = 4'd7;
    bus.load_val = 4'd11;
    bus.load = 1'b1;
    bus.en = 1'b1;
    tick();
    bus.load = 1'b0;
    checks++;
    if (bus.q !== 4'd11 || bus.tc !== 1'b1 || bus.co !== 1'b0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL load_over_max q=%0d tc=%0b co=%0b ovf=%0b required q=11 tc=1 co=0 ovf=0",
               bus.q, bus.tc, bus.co, bus.ovf);
    end
    tick();
    checks++;
    if (bus.q !== 4'd0 || bus.co !== 1'b1 || bus.ovf !== 1'b1) begin
      errors++;
      $display("FAIL over_max_wrap q=%0d co=%0b ovf=%0b required q=0 co=1 ovf=1", bus.q, bus.co, bus.ovf);
    end
    tick();
    checks++;
    if (bus.q !== 4'd1 || bus.co !== 1'b0 || bus.ovf !== 1'b1) begin
      errors++;
      $display("FAIL after_wrap q=%0d co=%0b ovf=%0b required q=1 co=0 ovf=1", bus.q, bus.co, bus.ovf);
    end
    bus.en = 1'b0;
  endtask

  task automatic test_async_reset();
    bus.max_val = 4'd15;
    bus.load_val = 4'd5;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    bus.en = 1'b1;
    tick();
    checks++;
    if (bus.q !== 4'd6 || bus.ovf !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset q=%0d ovf=%0b required q=6 ovf=1", bus.q, bus.ovf);
    end
    #3 rst = 1'b0;
    #1;
    checks++;
    if (bus.q !== 4'd0 || bus.co !== 1'b0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL async_reset q=%0d co=%0b ovf=%0b required q=0 co=0 ovf=0", bus.q, bus.co, bus.ovf);
    end
    #1 rst = 1'b1;
    tick();
    checks++;
    if (bus.q !== 4'd1 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL resume q=%0d ovf=%0b required q=1 ovf=0", bus.q, bus.ovf);
    end
    bus.en = 1'b0;
  endtask

  task automatic test_en_toggle();
    logic       en_seq [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] q_seq  [4] = '{4'd4, 4'd4, 4'd4, 4'd5};
    bus.max_val = 4'd15;
    bus.load_val = 4'd3;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.en = en_seq[i];
      tick();
      checks++;
      if (bus.q !== q_seq[i] || bus.co !== 1'b0) begin
        errors++;
        $display("FAIL en_toggle step=%0d q=%0d co=%0b required q=%0d co=0", i, bus.q, bus.co, q_seq[i]);
      end
    end
    bus.en = 1'b0;
  endtask

  task automatic test_max_zero();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    bus.max_val = 4'd0;
    bus.en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.q !== 4'd0 || bus.co !== 1'b1 || bus.tc !== 1'b1 || bus.ovf !== 1'b1) begin
        errors++;
        $display("FAIL max_zero edge=%0d q=%0d co=%0b tc=%0b ovf=%0b required q=0 co=1 tc=1 ovf=1",
                 i, bus.q, bus.co, bus.tc, bus.ovf);
      end
    end
    bus.en = 1'b0;
    tick();
    checks++;
    if (bus.co !== 1'b0 || bus.ovf !== 1'b1) begin
      errors++;
      $display("FAIL hold_after_zero co=%0b ovf=%0b required co=0 ovf=1", bus.co, bus.ovf);
    end
  endtask

  task automatic test_max_change();
    bus.max_val = 4'd15;
    bus.load_val = 4'd10;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    checks++;
    if (bus.tc !== 1'b0) begin
      errors++;
      $display("FAIL tc_before_change tc=%0b required 0", bus.tc);
    end
    bus.max_val = 4'd5;
    #1;
    checks++;
    if (bus.tc !== 1'b1) begin
      errors++;
      $display("FAIL tc_comb tc=%0b required 1", bus.tc);
    end
    bus.en = 1'b1;
    tick();
    checks++;
    if (bus.q !== 4'd0 || bus.co !== 1'b1) begin
      errors++;
      $display("FAIL max_change_wrap q=%0d co=%0b required q=0 co=1", bus.q, bus.co);
    end
    tick();
    checks++;
    if (bus.q !== 4'd1 || bus.co !== 1'b0) begin
      errors++;
      $display("FAIL max_change_next q=%0d co=%0b required q=1 co=0", bus.q, bus.co);
    end
    bus.en = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.en = 1'b0;
    bus.clr = 1'b0;
    bus.load = 1'b0;
    bus.load_val = 4'd0;
    bus.max_val = 4'd15;
    test_reset();
    test_count_full();
    test_decade();
    test_clr_priority();
    test_load_over_max();
    test_async_reset();
    test_en_toggle();
    test_max_zero();
    test_max_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/up_counter_mod.md
UP_COUNTER_MOD -- requirements
Module: up_counter_mod

Interface
REQ-001 Parameter: WIDTH, 4, counter width in bits (legal range 2..16).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-004 Port: en  input  1  count enable; increment when high.
REQ-005 Port: clr  input  1  synchronous clear of count and sticky flag.
REQ-006 Port: load  input  1  synchronous load strobe.
REQ-007 Port: load_val  input  WIDTH  value written to q on load.
REQ-008 Port: max_val  input  WIDTH  terminal (modulus-1) value; count range 0..max_val.
REQ-009 Port: q  output  WIDTH  current count, registered.
REQ-010 Port: tc  output  1  terminal count; high while q >= max_val, combinational from q and max_val.
REQ-011 Port: co  output  1  carry-out pulse, registered, high for exactly one cycle after each wrap.
REQ-012 Port: ovf  output  1  sticky wrap flag, registered; set on first wrap, held until clr or reset.

Function
REQ-013 The block SHALL evaluate controls per rising edge with priority clr > load > en > hold.
REQ-014 clr=1: q SHALL become 0, co 0, ovf 0, regardless of load/en.
REQ-015 load=1 (clr=0): q SHALL become load_val next cycle, co 0, ovf unchanged; no increment that cycle.
REQ-016 load_val > max_val SHALL be loaded unmodified; the following enabled increment SHALL wrap.
REQ-017 en=1, clr=0, load=0, q < max_val: q SHALL become q+1, co 0.
REQ-018 en=1, clr=0, load=0, q >= max_val: q SHALL become 0, co 1 for the next cycle only, ovf 1.
REQ-019 en=0, clr=0, load=0: q and ovf SHALL hold; co SHALL be 0.
REQ-020 Increment latency SHALL be one clock: q reflects an enabled edge immediately after that edge.
REQ-021 max_val=0: with en held, q SHALL stay 0 and co SHALL pulse every cycle (wrap every cycle).
REQ-022 max_val = all-ones: full 2^WIDTH sequence, wrap from 2^WIDTH-1 to 0; no arithmetic carry beyond WIDTH bits.
REQ-023 max_val changes mid-count SHALL take effect at the next edge; if q > new max_val, next enabled edge wraps to 0.
REQ-024 tc SHALL track q and max_val combinationally with no registering; tc=1 during the cycle preceding a wrap when en=1.
REQ-025 co SHALL never be high for two consecutive cycles except when REQ-021 applies.

Reset
REQ-026 rst=0 SHALL immediately (asynchronously, no clock required) force q=0, co=0, ovf=0.
REQ-027 While rst=0 the block SHALL ignore clk, en, clr, load.
REQ-028 Reset asserted mid-count SHALL abort counting; after rst deasserts the first enabled edge SHALL produce q=1.
REQ-029 rst deassertion is synchronous to clk externally; no internal synchronizer is required.

Verification
REQ-030 WIDTH=4, max_val=15, rst 0->1, en=1 for 20 edges -> q 1,2..15,0,1..4; co high one cycle after q 15->0; ovf=1 thereafter; tc=1 only while q=15.
REQ-031 max_val=9, en=1 -> q 0..9,0 repeating (decade counter); co pulses every 10 edges; tc=1 at q=9.
REQ-032 q=5, same edge clr=1, load=1, load_val=12, en=1 -> q=0, ovf=0; next edge load=1 only -> q=12.
REQ-033 max_val=7, load_val=11, load then en=1 -> q=11 then 0 with co=1, ovf=1; tc=1 while q=11.
REQ-034 Counting at q=6, rst pulsed low between edges -> q=0, co=0, ovf=0 immediately, before next clk edge; counting resumes at 1.
REQ-035 en toggled 1,0,0,1 from q=3, max_val=15 -> q 4,4,4,5; co stays 0.
